// File: rtl/wam_pkg.sv
// Shared types and defaults for the whack-a-mole player-side judge.
package wam_pkg;

  localparam int NUM_HOLES           = 9;
  localparam int LIVES_INIT_DEF      = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MOLE,
    ARMED,
    RESOLVED,
    OVER
  } judge_state_t;

  // Lives never wrap below zero.
  function automatic logic [1:0] dec_sat(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// One button: two-flop synchronizer, optional debounce filter, rising-edge detect.
// Debounce filter is built only when WAM_DEBOUNCE_EN is defined.
module button_conditioner
  import wam_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic sync0;
  logic sync1;
  logic filt;
  logic filt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= button;
      sync1 <= sync0;
    end
  end

`ifdef WAM_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync1 == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt  <= '0;
      filt <= sync1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign filt = sync1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_d <= 1'b0;
    end else begin
      filt_d <= filt;
    end
  end

  assign press = filt & ~filt_d;

endmodule

// File: rtl/hit_judge.sv
// Judges each lit mole as hit or miss from player buttons; keeps score and lives.
// Optional button debounce enabled by defining WAM_DEBOUNCE_EN.
module hit_judge
  import wam_pkg::*;
#(
  parameter int SCORE_W         = 8,
  parameter int LIVES_INIT      = LIVES_INIT_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] lights,
  input  logic [NUM_HOLES-1:0] buttons,
  output logic                 hit,
  output logic                 miss,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           lives,
  output logic                 game_over
);

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);

  logic [NUM_HOLES-1:0] press;
  logic [NUM_HOLES-1:0] target;
  logic [NUM_HOLES-1:0] target_next;
  logic [SCORE_W-1:0]   score_next;
  logic [1:0]           lives_next;
  logic [1:0]           lives_dec;
  logic                 hit_next;
  logic                 miss_next;
  judge_state_t         state;
  judge_state_t         state_next;

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_cond
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk   (clk),
      .reset (reset),
      .button(buttons[i]),
      .press (press[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      target    <= '0;
      score     <= '0;
      lives     <= 2'd0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_next;
      target    <= target_next;
      score     <= score_next;
      lives     <= lives_next;
      hit       <= hit_next;
      miss      <= miss_next;
      game_over <= (state_next == OVER);
    end
  end

  // A correct press wins over a wrong press or a mole dropping in the same cycle.
  always_comb begin
    state_next  = state;
    target_next = target;
    score_next  = score;
    lives_next  = lives;
    hit_next    = 1'b0;
    miss_next   = 1'b0;
    lives_dec   = dec_sat(lives);

    case (state)
      IDLE, OVER: begin
        if (start) begin
          score_next = '0;
          lives_next = LIVES_LOAD;
          state_next = WAIT_MOLE;
        end
      end
      WAIT_MOLE: begin
        if (lights != '0) begin
          target_next = lights;
          state_next  = ARMED;
        end
      end
      ARMED: begin
        if ((press & target) != '0) begin
          hit_next   = 1'b1;
          score_next = (score == SCORE_MAX) ? score : score + 1'b1;
          state_next = RESOLVED;
        end else if ((press != '0) || ((lights & target) == '0)) begin
          miss_next  = 1'b1;
          lives_next = lives_dec;
          state_next = (lives_dec == 2'd0) ? OVER : RESOLVED;
        end
      end
      RESOLVED: begin
        if (lights == '0) begin
          state_next = WAIT_MOLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: vector table plus scoreboard of hit/miss events.
module tb_hit_judge;
  import wam_pkg::*;

`ifdef WAM_DEBOUNCE_EN
  localparam int HOLD = DEBOUNCE_CYCLES_DEF + 3;
`else
  localparam int HOLD = 3;
`endif

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [1:0] lives;
    logic       over;
  } ev_t;

  typedef struct packed {
    logic [8:0] lights;
    logic [8:0] btns;
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [1:0] lives;
    logic       over;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [8:0] lights;
  logic [8:0] buttons;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic       hit2;
  logic       miss2;
  logic [1:0] score2;
  logic [1:0] lives2;
  logic       game_over2;

  int   checks   = 0;
  int   failures = 0;
  ev_t  sb[$];
  ev_t  mon_exp;
  vec_t vecs[7];

  hit_judge u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .lights   (lights),
    .buttons  (buttons),
    .hit      (hit),
    .miss     (miss),
    .score    (score),
    .lives    (lives),
    .game_over(game_over)
  );

  // Narrow score copy to exercise saturation with few hits.
  hit_judge #(.SCORE_W(2)) u_dut_sat (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .lights   (lights),
    .buttons  (buttons),
    .hit      (hit2),
    .miss     (miss2),
    .score    (score2),
    .lives    (lives2),
    .game_over(game_over2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (hit || miss)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse actual hit=%0b miss=%0b required none", hit, miss);
      end else begin
        mon_exp = sb.pop_front();
        check_output("event", 32'({hit, miss, score, lives, game_over}), 32'(mon_exp));
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic press(input logic [8:0] mask);
    buttons = mask;
    repeat (HOLD) @(negedge clk);
    buttons = '0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic start_game();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("start_state", 32'({score, lives, game_over}), 32'({8'd0, 2'd3, 1'b0}));
  endtask

  task automatic apply_stimulus(input vec_t v);
    ev_t e;
    @(negedge clk);
    lights = v.lights;
    repeat (3) @(negedge clk);
    e.hit   = v.hit;
    e.miss  = v.miss;
    e.score = v.score;
    e.lives = v.lives;
    e.over  = v.over;
    sb.push_back(e);
    if (v.btns != '0) press(v.btns);
    else lights = '0;
    wait_drain("vec_event");
    if (v.btns != '0 && !v.over) press(v.lights);
    lights = '0;
    repeat (3) @(negedge clk);
    wait_drain("vec_quiet");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ev_t e;
    vecs[0] = '{9'h010, 9'h010, 1'b1, 1'b0, 8'd1, 2'd3, 1'b0};
    vecs[1] = '{9'h001, 9'h004, 1'b0, 1'b1, 8'd1, 2'd2, 1'b0};
    vecs[2] = '{9'h100, 9'h000, 1'b0, 1'b1, 8'd1, 2'd1, 1'b0};
    vecs[3] = '{9'h042, 9'h040, 1'b1, 1'b0, 8'd2, 2'd1, 1'b0};
    vecs[4] = '{9'h008, 9'h00C, 1'b1, 1'b0, 8'd3, 2'd1, 1'b0};
    vecs[5] = '{9'h100, 9'h100, 1'b1, 1'b0, 8'd4, 2'd1, 1'b0};
    vecs[6] = '{9'h080, 9'h001, 1'b0, 1'b1, 8'd4, 2'd0, 1'b1};

    reset   = 1'b0;
    start   = 1'b0;
    lights  = '0;
    buttons = '0;
    #12;
    check_output("reset_outputs", 32'({hit, miss, score, lives, game_over}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_output("idle_hold", 32'({score, lives, game_over}), 32'd0);

    start_game();
    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);
    check_output("sat_score2", 32'(score2), 32'd3);
    check_output("over_hold", 32'({score, lives, game_over}), 32'({8'd4, 2'd0, 1'b1}));
    press(9'h080);
    check_output("over_press", 32'({score, lives, game_over}), 32'({8'd4, 2'd0, 1'b1}));

    start_game();
    press(9'h001);
    wait_drain("wait_mole_press");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lights = 9'h100;
      repeat (3) @(negedge clk);
      e = '{1'b0, 1'b1, 8'd0, 2'(2 - i), (i == 2)};
      sb.push_back(e);
      lights = '0;
      @(negedge clk);
      check_output("timeout_latency", 32'(miss), 32'd1);
      wait_drain("timeout_event");
    end
    check_output("game_over", 32'({lives, game_over}), 32'({2'd0, 1'b1}));

    start_game();
    @(negedge clk);
    lights = 9'h010;
    repeat (3) @(negedge clk);
    e = '{1'b1, 1'b0, 8'd1, 2'd3, 1'b0};
    sb.push_back(e);
`ifdef WAM_DEBOUNCE_EN
    press(9'h010);
`else
    buttons = 9'h010;
    @(negedge clk);
    check_output("lat_k", 32'(hit), 32'd0);
    @(negedge clk);
    check_output("lat_k1", 32'(hit), 32'd0);
    @(negedge clk);
    check_output("lat_k2", 32'(hit), 32'd1);
    buttons = '0;
    repeat (HOLD) @(negedge clk);
`endif
    wait_drain("latency_event");
    lights = '0;
    repeat (3) @(negedge clk);
    lights = 9'h001;
    repeat (3) @(negedge clk);
`ifdef WAM_DEBOUNCE_EN
    buttons = 9'h001;
    repeat (DEBOUNCE_CYCLES_DEF / 2) @(negedge clk);
    buttons = '0;
    repeat (3 * DEBOUNCE_CYCLES_DEF) @(negedge clk);
    wait_drain("bounce_quiet");
`endif
    check_output("pre_reset", 32'({score, lives}), 32'({8'd1, 2'd3}));

    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset", 32'({hit, miss, score, lives, game_over}), 32'd0);
    sb.delete();
    @(negedge clk);
    lights = '0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    check_output("post_reset_idle", 32'({hit, miss, score, lives, game_over}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
# hit_judge

Player-side counterpart to the light controller in the whack-a-mole game. The light controller lights one of nine moles; this block reads the nine player buttons, judges each lit mole as a hit or a miss, and keeps score and lives. It sits between the board push-buttons and the score/HEX display logic, taking the controller's `lights[8:0]` as its target input.

## Interface
- `SCORE_W`, default 8: score counter width.
- `LIVES_INIT`, default 3: lives loaded at game start; must fit in 2 bits.
- `DEBOUNCE_CYCLES`, default 16: stable-sample count. Used only with `WAM_DEBOUNCE_EN`.

- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-low; clock `clk`.
- `start`  in  1  level or pulse; begins a new game from IDLE or OVER.
- `lights`  in  9  mole mask from the light controller; 0 means no mole is up.
- `buttons`  in  9  raw player buttons, active-high, asynchronous to `clk`.
- `hit`  out  1  one-cycle pulse on a correct whack.
- `miss`  out  1  one-cycle pulse on a wrong button or a mole timeout.
- `score`  out  SCORE_W  hits this game, saturating.
- `lives`  out  2  remaining lives.
- `game_over`  out  1  high while in OVER.

## Operation
- **Button conditioning.** Each bit passes through a two-flop synchronizer, then the optional debounce filter, then a rising-edge detector. The result is `press[8:0]`, one cycle wide per press. Held buttons never repeat.
- **FSM states:** IDLE, WAIT_MOLE, ARMED, RESOLVED, OVER.
- **IDLE.** Outputs hold their values. On `start`: `score` is cleared to 0, `lives` is loaded with LIVES_INIT, and the FSM moves to WAIT_MOLE.
- **WAIT_MOLE.** Presses are ignored. When `lights != 0`, `lights` is latched into `target` and the FSM moves to ARMED.
- **ARMED.** Priority order, evaluated once per cycle:
  1. `press & target` nonzero: `hit`, `score` +1 (saturating at 2^SCORE_W-1), go to RESOLVED.
  2. `press` nonzero but not on target: `miss`, `lives` -1.
  3. `lights & target` is 0 (mole gone): `miss`, `lives` -1.
- **After a miss.** If `lives` reaches 0, go to OVER; otherwise go to RESOLVED.
- **Simultaneous events.**
  - A correct press in the same cycle the mole drops counts as a hit.
  - A correct press plus a wrong press in the same cycle counts as a hit.
- **Multi-bit `lights`.** Any set bit is a valid target.
- **RESOLVED.** Presses are ignored. When `lights == 0`, go to WAIT_MOLE. Each mole is therefore judged at most once.
- **OVER.** `game_over` = 1; `score` is held. `start` restarts the game exactly as from IDLE.
- **`lives` arithmetic.** Never decrements below 0.
- **Reset.** Any state goes to IDLE.
  - Outputs: `hit` = 0, `miss` = 0, `score` = 0, `lives` = 0, `game_over` = 0.
  - Internal: `target` = 0; synchronizer, filter and edge flops = 0.

## Timing
- All outputs are registered.
- **Button latency (without debounce).** Button high at sampling edge k gives `press` during the cycle after edge k+1. `hit`/`miss` and the `score`/`lives` update appear after edge k+2 (three edges).
- **Button latency (with `WAM_DEBOUNCE_EN`).** Add DEBOUNCE_CYCLES edges.
- **Mole timeout latency.** `lights` falling at edge m produces `miss` after edge m+1. `lights` is not synchronized because it is generated on `clk`.
- **Pulse width.** `hit` and `miss` are exactly one cycle and mutually exclusive.
- **Start latency.** `start` sampled at edge s: `score`/`lives` update and the FSM enters WAIT_MOLE at that edge.
- **Asynchronous reset.** Reset asserted mid-judgement clears outputs immediately without waiting for a clock edge.

## Configuration
- **`WAM_DEBOUNCE_EN` defined.** Per-button counter. The filtered level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current filtered level. Any matching sample clears the counter.
- **`WAM_DEBOUNCE_EN` undefined.** Filtered level = synchronizer output. No counters are synthesized.

## Structure
- **Package `wam_pkg`:**
  - state enum typedef `judge_state_t`;
  - `NUM_HOLES` = 9;
  - default LIVES_INIT;
  - default DEBOUNCE_CYCLES.
- **Sub-module `button_conditioner`:** synchronizer, optional debounce, and rise detect for one bit. Instantiated NUM_HOLES times via generate.
- **Top level:** FSM, `target` register, score and lives counters.

## Test plan
- **Hit.** `start`; `lights` = 9'h010; pulse `buttons[4]` -> one `hit` pulse, `score` = 1, `lives` = 3. Extra presses before `lights` = 0 have no effect.
- **Wrong button.** `lights` = 9'h001; press `buttons[2]` -> `miss`, `lives` = 2, FSM goes to RESOLVED, `score` unchanged.
- **Timeout.** `lights` = 9'h100, then 0 with no press -> `miss` one cycle later, `lives` decrements.
- **Game over.** Three consecutive misses from `lives` = 3 -> `lives` = 0, `game_over` = 1. Next `start` -> `score` = 0, `lives` = 3, `game_over` = 0.
- **Simultaneous.** Correct and wrong buttons pressed in the same cycle -> `hit` only. With SCORE_W = 2, score 3 plus a hit -> stays 3.
- **Reset mid-game.** Pull `reset` low while ARMED -> all outputs 0 immediately. With `WAM_DEBOUNCE_EN`, a bounce shorter than DEBOUNCE_CYCLES -> no `press`.
